// File: rtl/reorder_buffer.sv
// In-order commit stage: 16-entry circular reorder buffer.
// Hands out rename tags, collects results, retires in order, flushes on mispredict.
module reorder_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        alloc_valid,
  input  logic        alloc_has_dest,
  input  logic        alloc_is_branch,
  input  logic [4:0]  alloc_rd,
  input  logic [31:0] alloc_value,
  output logic        alloc_ready,
  output logic [3:0]  alloc_tag,
  input  logic        simple_ins_commit,
  input  logic [3:0]  simple_ins_rename,
  input  logic        wb_valid,
  input  logic [3:0]  wb_tag,
  input  logic [31:0] wb_value,
  input  logic        wb_mispredict,
  input  logic [31:0] wb_target,
  output logic        register_update_flag,
  output logic [4:0]  register_commit_dest,
  output logic [31:0] register_commit_value,
  output logic [3:0]  rename_of_commit_ins,
  output logic        register_flush,
  output logic [31:0] flush_pc
);

  logic [15:0] busy;
  logic [15:0] done;
  logic [15:0] has_dest;
  logic [15:0] is_branch;
  logic [15:0] mispred;
  logic [4:0]  dest   [16];
  logic [31:0] value  [16];
  logic [31:0] target [16];

  logic [3:0]  head;
  logic [3:0]  tail;
  logic [4:0]  count;

  logic alloc_fire;
  logic commit_fire;
  logic flush_fire;
  logic wb_hit;
  logic simple_hit;

  assign alloc_ready = (count != 5'd16) && !register_flush;
  assign alloc_tag   = tail;
  assign alloc_fire  = rdy && alloc_valid && alloc_ready;
  assign commit_fire = rdy && busy[head] && done[head];
  assign flush_fire  = commit_fire && is_branch[head] && mispred[head];
  assign wb_hit      = wb_valid && busy[wb_tag];
  assign simple_hit  = simple_ins_commit && busy[simple_ins_rename];

  // Control state: occupancy, pointers, commit and flush pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy                  <= '0;
      done                  <= '0;
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      register_update_flag  <= 1'b0;
      register_commit_dest  <= '0;
      register_commit_value <= '0;
      rename_of_commit_ins  <= '0;
      register_flush        <= 1'b0;
      flush_pc              <= '0;
    end else if (!rdy) begin
      register_update_flag <= 1'b0;
      register_flush       <= 1'b0;
    end else begin
      register_update_flag <= commit_fire && has_dest[head];
      register_flush       <= flush_fire;
      if (commit_fire) begin
        register_commit_dest  <= dest[head];
        register_commit_value <= value[head];
        rename_of_commit_ins  <= head;
      end
      if (flush_fire) begin
        flush_pc <= target[head];
        busy     <= '0;
        done     <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (wb_hit)
          done[wb_tag] <= 1'b1;
        if (simple_hit)
          done[simple_ins_rename] <= 1'b1;
        if (alloc_fire) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
          tail       <= tail + 4'd1;
        end
        if (commit_fire) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= head + 4'd1;
        end
        count <= count + {4'd0, alloc_fire} - {4'd0, commit_fire};
      end
    end
  end

  // Entry payload: only meaningful while the entry is busy, so no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (wb_hit) begin
        value[wb_tag]   <= wb_value;
        target[wb_tag]  <= wb_target;
        mispred[wb_tag] <= wb_mispredict;
      end
      if (alloc_fire) begin
        has_dest[tail]  <= alloc_has_dest;
        is_branch[tail] <= alloc_is_branch;
        dest[tail]      <= alloc_rd;
        value[tail]     <= alloc_value;
        mispred[tail]   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer.
// A program-order queue model predicts commit and flush pulses.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alloc_valid;
  logic        alloc_has_dest;
  logic        alloc_is_branch;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_value;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        simple_ins_commit;
  logic [3:0]  simple_ins_rename;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic [31:0] wb_target;
  logic        register_update_flag;
  logic [4:0]  register_commit_dest;
  logic [31:0] register_commit_value;
  logic [3:0]  rename_of_commit_ins;
  logic        register_flush;
  logic [31:0] flush_pc;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest),
    .alloc_is_branch(alloc_is_branch), .alloc_rd(alloc_rd),
    .alloc_value(alloc_value), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .simple_ins_commit(simple_ins_commit),
    .simple_ins_rename(simple_ins_rename),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .register_update_flag(register_update_flag),
    .register_commit_dest(register_commit_dest),
    .register_commit_value(register_commit_value),
    .rename_of_commit_ins(rename_of_commit_ins),
    .register_flush(register_flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic        hd;
    logic        br;
    logic        rd_y;
    logic        mp;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic        flag;
    logic        fl;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  tag;
    logic [31:0] pc;
  } exp_t;

  ent_t q[$];
  exp_t exp_q[$];
  logic [3:0] next_tag;
  logic flush_last;
  int errors = 0;
  int checks = 0;

  // Reference model: instructions in program order, oldest first.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_q.delete();
      next_tag = '0;
      flush_last = 1'b0;
    end else if (!rdy) begin
      flush_last = 1'b0;
    end else begin : step
      bit can_alloc;
      bit do_commit;
      bit do_flush;
      ent_t f;
      ent_t e;
      can_alloc = (q.size() != 16) && !flush_last;
      flush_last = 1'b0;
      do_commit = (q.size() > 0) && q[0].rd_y;
      do_flush = 1'b0;
      if (do_commit) begin
        f = q[0];
        do_flush = f.br && f.mp;
        if (f.hd || do_flush)
          exp_q.push_back('{f.hd, do_flush, f.rd, f.val, f.tag, f.tgt});
      end
      foreach (q[i]) begin
        if (wb_valid && q[i].tag == wb_tag) begin
          q[i].rd_y = 1'b1;
          q[i].val = wb_value;
          q[i].mp = wb_mispredict;
          q[i].tgt = wb_target;
        end
        if (simple_ins_commit && q[i].tag == simple_ins_rename)
          q[i].rd_y = 1'b1;
      end
      if (do_flush) begin
        q.delete();
        next_tag = '0;
        flush_last = 1'b1;
      end else begin
        if (alloc_valid && can_alloc) begin
          e.tag = next_tag;
          e.hd = alloc_has_dest;
          e.br = alloc_is_branch;
          e.rd_y = 1'b0;
          e.mp = 1'b0;
          e.rd = alloc_rd;
          e.val = alloc_value;
          e.tgt = '0;
          q.push_back(e);
          next_tag = next_tag + 4'd1;
        end
        if (do_commit)
          void'(q.pop_front());
      end
    end
  end

  // Monitor: compare presented pulses against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin : mon
      exp_t x;
      checks++;
      if (alloc_tag !== next_tag) begin
        errors++;
        $display("FAIL alloc_tag got=%0d want=%0d", alloc_tag, next_tag);
      end
      checks++;
      if (alloc_ready !== ((q.size() != 16) && !flush_last)) begin
        errors++;
        $display("FAIL alloc_ready got=%b want=%b", alloc_ready,
                 (q.size() != 16) && !flush_last);
      end
      if (register_update_flag || register_flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse flag=%b flush=%b tag=%0d",
                   register_update_flag, register_flush,
                   rename_of_commit_ins);
        end else begin
          x = exp_q.pop_front();
          if (register_update_flag !== x.flag ||
              register_flush !== x.fl ||
              (x.flag && (register_commit_dest !== x.rd ||
                          register_commit_value !== x.val ||
                          rename_of_commit_ins !== x.tag)) ||
              (x.fl && flush_pc !== x.pc)) begin
            errors++;
            $display("FAIL commit got f=%b fl=%b rd=%0d v=%h t=%0d pc=%h want f=%b fl=%b rd=%0d v=%h t=%0d pc=%h",
                     register_update_flag, register_flush,
                     register_commit_dest, register_commit_value,
                     rename_of_commit_ins, flush_pc,
                     x.flag, x.fl, x.rd, x.val, x.tag, x.pc);
          end
        end
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missing_pulse got=none want=tag%0d", exp_q[0].tag);
        exp_q.delete();
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic clr();
    rdy = 1'b1;
    alloc_valid = 1'b0;
    alloc_has_dest = 1'b0;
    alloc_is_branch = 1'b0;
    alloc_rd = '0;
    alloc_value = '0;
    simple_ins_commit = 1'b0;
    simple_ins_rename = '0;
    wb_valid = 1'b0;
    wb_tag = '0;
    wb_value = '0;
    wb_mispredict = 1'b0;
    wb_target = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clr();
    end
  endtask

  task automatic do_alloc(input logic hd, input logic br,
                          input logic [4:0] rd, input logic [31:0] v);
    @(negedge clk);
    clr();
    alloc_valid = 1'b1;
    alloc_has_dest = hd;
    alloc_is_branch = br;
    alloc_rd = rd;
    alloc_value = v;
  endtask

  task automatic do_wb(input logic [3:0] t, input logic [31:0] v,
                       input logic mp, input logic [31:0] tg);
    @(negedge clk);
    clr();
    wb_valid = 1'b1;
    wb_tag = t;
    wb_value = v;
    wb_mispredict = mp;
    wb_target = tg;
  endtask

  task automatic do_simple(input logic [3:0] t);
    @(negedge clk);
    clr();
    simple_ins_commit = 1'b1;
    simple_ins_rename = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    #2 rst = 1'b1;
    #1;
    chk("rst_flag", 32'(register_update_flag), 32'd0);
    chk("rst_flush", 32'(register_flush), 32'd0);
    chk("rst_dest", 32'(register_commit_dest), 32'd0);
    chk("rst_value", register_commit_value, 32'd0);
    chk("rst_rename", 32'(rename_of_commit_ins), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_reset();

    do_alloc(1, 0, 5'd5, 0);
    do_alloc(1, 0, 5'd6, 0);
    do_alloc(1, 0, 5'd7, 0);
    do_wb(4'd2, 32'h22, 0, 0);
    idle(2);
    do_wb(4'd0, 32'h11, 0, 0);
    idle(2);
    do_wb(4'd1, 32'h33, 0, 0);
    idle(4);

    do_alloc(0, 0, 5'd0, 0);
    do_simple(4'd3);
    do_alloc(1, 0, 5'd3, 32'h12345000);
    idle(1);
    do_simple(4'd4);
    idle(4);

    do_reset();
    for (int i = 0; i < 17; i++)
      do_alloc(1, 0, 5'(i), 32'(i * 3));
    idle(2);
    do_wb(4'd0, 32'hA0, 0, 0);
    idle(3);
    do_alloc(1, 0, 5'd9, 32'h99);
    idle(2);
    for (int i = 1; i < 16; i++)
      do_wb(4'(i), 32'(i + 100), 0, 0);
    do_wb(4'd0, 32'hB0, 0, 0);
    idle(20);

    do_reset();
    do_alloc(1, 0, 5'd10, 0);
    do_alloc(1, 1, 5'd1, 0);
    do_alloc(1, 0, 5'd11, 0);
    do_alloc(1, 0, 5'd12, 0);
    do_wb(4'd1, 32'h104, 1, 32'h200);
    do_wb(4'd0, 32'h50, 0, 0);
    do_wb(4'd2, 32'h60, 0, 0);
    idle(5);

    do_alloc(1, 0, 5'd20, 0);
    do_wb(4'd0, 32'h77, 0, 0);
    repeat (3) begin
      @(negedge clk);
      clr();
      rdy = 1'b0;
    end
    idle(4);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      clr();
      rdy = ($urandom % 8) != 0;
      alloc_valid = 1'($urandom % 2);
      alloc_has_dest = ($urandom % 4) != 0;
      alloc_is_branch = ($urandom % 4) == 0;
      alloc_rd = 5'($urandom);
      alloc_value = $urandom;
      if (q.size() > 0 && ($urandom % 2) == 1) begin
        wb_valid = 1'b1;
        wb_tag = q[$urandom_range(0, q.size() - 1)].tag;
        wb_value = $urandom;
        wb_mispredict = ($urandom % 6) == 0;
        wb_target = $urandom;
      end else if (($urandom % 8) == 0) begin
        wb_valid = 1'b1;
        wb_tag = 4'($urandom);
        wb_value = $urandom;
        wb_mispredict = 1'($urandom % 2);
        wb_target = $urandom;
      end
      if (($urandom % 4) == 0) begin
        simple_ins_commit = 1'b1;
        simple_ins_rename = 4'($urandom);
      end
    end
    idle(2);

    for (int i = 0; i < 5; i++)
      do_alloc(1, 0, 5'(i + 1), 32'(i));
    idle(1);
    do_reset();
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
